// File: rtl/sdram_access_arbiter.sv
// Purpose: arbitrates one fetch (read) and one writeback (write) requester onto a single SDRAM command port.
// Latency: grant and command issue 1 edge after the request; rd_valid 1 edge after datareadvalid; wr_done on the accept edge.
// Backpressure: commands are held stable while sdram_waitrequest is high; requesters hold their level requests until completion.
//
// Ports:
//   clk, n_rst, clear                         - clock, async active-low reset, synchronous abort
//   rd_req/rd_addr                             - fetch request side
//   wr_req/wr_addr/wr_data                     - writeback request side
//   sdram_waitrequest/datareadvalid/readdata   - SDRAM responses
//   sdram_read_en/write_en, address_sdram,
//   sdram_writedata                            - SDRAM command (all registered)
//   rd_grant/wr_grant, rd_data/rd_valid,
//   wr_done, rd_error                          - one-cycle status pulses back to requesters
module sdram_access_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 26
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              sdram_waitrequest,
    input  logic              sdram_datareadvalid,
    input  logic [31:0]       sdram_readdata,
    output logic              sdram_read_en,
    output logic              sdram_write_en,
    output logic [ADDR_W-1:0] address_sdram,
    output logic [31:0]       sdram_writedata,
    output logic              rd_grant,
    output logic              wr_grant,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              rd_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        READ_WAIT = 2'd2,
        WRITE     = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_wr_q, last_wr_d;   // 1: write was served last
    logic                read_en_q, read_en_d;
    logic                write_en_q, write_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rd_grant_q, rd_grant_d;
    logic                wr_grant_q, wr_grant_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_error_q, rd_error_d;

    logic                rd_win;
    logic                timeout;

    // On a tie the side not served last wins.
    assign rd_win  = rd_req && (!wr_req || last_wr_q);
    // Fires on the TIMEOUT_CYCLES-th edge spent in READ_WAIT.
    assign timeout = (cnt_q == CNT_LAST);

    // State register (all flops, including registered outputs)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_grant_q <= 1'b0;
            wr_grant_q <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_grant_q <= rd_grant_d;
            wr_grant_q <= wr_grant_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            rd_error_q <= rd_error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd_win)      state_d = READ;
                    else if (wr_req) state_d = WRITE;
                end
                READ:      if (!sdram_waitrequest)               state_d = READ_WAIT;
                READ_WAIT: if (sdram_datareadvalid || timeout)   state_d = IDLE;
                WRITE:     if (!sdram_waitrequest)               state_d = IDLE;
                default:                                         state_d = IDLE;
            endcase
        end
    end

    // Output / datapath logic: every output is the registered image of these values.
    always_comb begin
        read_en_d  = (state_d == READ);
        write_en_d = (state_d == WRITE);
        rd_grant_d = (state_q == IDLE) && (state_d == READ);
        wr_grant_d = (state_q == IDLE) && (state_d == WRITE);
        rd_valid_d = !clear && (state_q == READ_WAIT) && sdram_datareadvalid;
        rd_error_d = !clear && (state_q == READ_WAIT) && !sdram_datareadvalid && timeout;
        wr_done_d  = !clear && (state_q == WRITE) && !sdram_waitrequest;

        // Command fields latch only at grant, so later request changes cannot leak in.
        addr_d = addr_q;
        if (rd_grant_d)      addr_d = rd_addr;
        else if (wr_grant_d) addr_d = wr_addr;

        wdata_d   = wr_grant_d ? wr_data : wdata_q;
        rd_data_d = rd_valid_d ? sdram_readdata : rd_data_q;

        // Counter runs only while staying in READ_WAIT; any other path (entry, exit, clear) zeroes it.
        cnt_d = ((state_q == READ_WAIT) && (state_d == READ_WAIT)) ? cnt_q + CNT_W'(1) : '0;

        last_wr_d = last_wr_q;
        if (clear)           last_wr_d = 1'b1;
        else if (rd_grant_d) last_wr_d = 1'b0;
        else if (wr_grant_d) last_wr_d = 1'b1;
    end

    assign sdram_read_en   = read_en_q;
    assign sdram_write_en  = write_en_q;
    assign address_sdram   = addr_q;
    assign sdram_writedata = wdata_q;
    assign rd_grant        = rd_grant_q;
    assign wr_grant        = wr_grant_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign wr_done         = wr_done_q;
    assign rd_error        = rd_error_q;

endmodule

// File: doc/sdram_access_arbiter.md
SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles in READ_WAIT before abort.
REQ-002 Parameter ADDR_W, default 26, SDRAM word address width.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 n_rst  in  1  asynchronous active-low reset.
REQ-005 clear  in  1  synchronous abort and priority reset, driven by the start_flag pulse.
REQ-006 rd_req  in  1  fetch request; level, held until rd_valid or rd_error.
REQ-007 rd_addr  in  ADDR_W  fetch address.
REQ-008 wr_req  in  1  writeback request; level, held until wr_done.
REQ-009 wr_addr  in  ADDR_W  writeback address.
REQ-010 wr_data  in  32  writeback pixel word.
REQ-011 sdram_waitrequest  in  1  SDRAM stall; command held while high.
REQ-012 sdram_datareadvalid  in  1  read data valid strobe.
REQ-013 sdram_readdata  in  32  read data.
REQ-014 sdram_read_en, sdram_write_en  out  1 each  SDRAM commands.
REQ-015 address_sdram  out  ADDR_W  command address.
REQ-016 sdram_writedata  out  32  command write data.
REQ-017 rd_grant, wr_grant  out  1 each  one-cycle acceptance pulses.
REQ-018 rd_data  out  32  captured read word; rd_valid out 1 one-cycle pulse.
REQ-019 wr_done, rd_error  out  1 each  one-cycle completion/timeout pulses.

Function
REQ-020 The block SHALL implement states IDLE, READ, READ_WAIT, WRITE; all outputs registered.
REQ-021 In IDLE with one request high, the next edge SHALL enter READ or WRITE, load address_sdram (and sdram_writedata for write), assert the matching enable and pulse the matching grant in that same cycle.
REQ-022 With rd_req and wr_req both high in IDLE, the requester not served last SHALL win; last_served SHALL reset to WRITE, so read wins the first tie.
REQ-023 In READ, sdram_read_en SHALL stay high with address stable while sdram_waitrequest=1; on an edge with waitrequest=0, read_en SHALL drop and state SHALL become READ_WAIT.
REQ-024 In READ_WAIT, on sdram_datareadvalid=1 the block SHALL capture sdram_readdata into rd_data, pulse rd_valid next cycle and return to IDLE.
REQ-025 The READ_WAIT cycle counter SHALL clear on entry; on reaching TIMEOUT_CYCLES without datareadvalid, the block SHALL pulse rd_error, leave rd_data unchanged and return to IDLE.
REQ-026 In WRITE, sdram_write_en, address and data SHALL stay stable while waitrequest=1; on an edge with waitrequest=0, write_en SHALL drop, wr_done SHALL pulse and state SHALL become IDLE.
REQ-027 A completion cycle (rd_valid/wr_done/rd_error) SHALL be spent in IDLE; arbitration resumes the following edge. Minimum turnaround is 2 cycles for write and 3 for read.
REQ-028 sdram_datareadvalid outside READ_WAIT SHALL be ignored.
REQ-029 Requests dropped before grant SHALL be ignored; request changes after grant SHALL not affect the latched command.
REQ-030 clear=1 SHALL force IDLE, deassert both enables and all pulses, reset last_served to WRITE and zero the counter; clear has priority over every other event.
REQ-031 Never SHALL read_en and write_en be high together; at most one grant/completion pulse per cycle.

Reset
REQ-032 While n_rst=0: state IDLE; all enables, grants, pulses 0; address_sdram, sdram_writedata, rd_data 0; counter 0; last_served WRITE.
REQ-033 Reset assertion mid-transfer SHALL drop enables immediately, without waiting for a clock edge.

Verification
REQ-034 rd_req, rd_addr=0x0000100, waitrequest=0, datareadvalid 4 cycles later with 0xDEADBEEF -> rd_grant and read_en 1 cycle, rd_data=0xDEADBEEF, rd_valid single pulse.
REQ-035 rd_req and wr_req both high continuously -> grants alternate R,W,R,W; enables never overlap.
REQ-036 wr_req with waitrequest high 5 cycles -> write_en, address and data stable 6 cycles, then wr_done pulse.
REQ-037 Read with no datareadvalid, TIMEOUT_CYCLES=8 -> rd_error pulses after 8 READ_WAIT cycles, then IDLE; a late datareadvalid is ignored.
REQ-038 clear asserted during WRITE with waitrequest=1 -> write_en 0 next edge, no wr_done, then a tie grants read first.
REQ-039 n_rst low mid-READ -> read_en 0 asynchronously, all outputs at reset values.
